// File: rtl/fp_sqrt_pkg.sv
// Shared types, constants and special-operand decode for the FP square-root sequencer.
// Operands use IEEE-754 layout; single precision occupies bits [31:0].
package fp_sqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        ITER,
        ROUND,
        DONE
    } state_t;

    localparam int OFFSET_SP = 63;
    localparam int OFFSET_DP = 511;
    localparam int ITERS_SP  = 26;
    localparam int ITERS_DP  = 55;

    localparam logic [63:0] QNAN_SP  = 64'h0000_0000_7FC0_0000;
    localparam logic [63:0] QNAN_DP  = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] QUIET_DP = 64'h0008_0000_0000_0000;
    localparam logic [31:0] QUIET_SP = 32'h0040_0000;

    // True when the operand bypasses the iterative datapath.
    function automatic logic is_special(input logic dp, input logic [63:0] op);
        if (dp) begin
            return (&op[62:52]) || (op[62:52] == 11'd0) || op[63];
        end
        return (&op[30:23]) || (op[30:23] == 8'd0) || op[31];
    endfunction

    // Returns {invalid, result}. Subnormals are flushed before the sign test,
    // so a negative subnormal yields -0 rather than an invalid NaN.
    function automatic logic [64:0] special_result(input logic dp, input logic [63:0] op);
        logic sign;
        logic exp_ones;
        logic exp_zero;
        logic frac_nz;
        if (dp) begin
            sign     = op[63];
            exp_ones = &op[62:52];
            exp_zero = (op[62:52] == 11'd0);
            frac_nz  = |op[51:0];
        end else begin
            sign     = op[31];
            exp_ones = &op[30:23];
            exp_zero = (op[30:23] == 8'd0);
            frac_nz  = |op[22:0];
        end
        if (exp_ones && frac_nz) begin
            return {1'b0, dp ? (op | QUIET_DP) : {32'd0, op[31:0] | QUIET_SP}};
        end else if (exp_zero) begin
            return {1'b0, dp ? {sign, 63'd0} : {32'd0, sign, 31'd0}};
        end else if (sign) begin
            return {1'b1, dp ? QNAN_DP : QNAN_SP};
        end
        // Only +inf remains here.
        return {1'b0, dp ? op : {32'd0, op[31:0]}};
    endfunction

endpackage

// File: rtl/fp_sqrt_if.sv
// Issue/writeback handshake between the FPU issue logic and the square-root sequencer.
interface fp_sqrt_if;
    logic        start;
    logic        op_type;
    logic [63:0] operand;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        invalid;

    modport master (
        output start, op_type, operand,
        input  busy, done, result, invalid
    );

    modport slave (
        input  start, op_type, operand,
        output busy, done, result, invalid
    );
endinterface

// File: rtl/exponent_handler.sv
// Result exponent of a square root: halve the biased exponent and re-bias.
module exponent_handler
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W = 11
) (
    input  logic [EXP_W-1:0] in_exp,
    input  logic             dp,
    output logic [EXP_W-1:0] out_exp
);

    logic [EXP_W-1:0] offset;

    assign offset  = dp ? EXP_W'(OFFSET_DP) : EXP_W'(OFFSET_SP);
    assign out_exp = (in_exp >> 1) + offset + {{(EXP_W-1){1'b0}}, in_exp[0]};

endmodule

// File: rtl/sqrt_step.sv
// One restoring square-root step: bring down a radicand bit pair, trial-subtract
// (4*root + 1), keep the difference if non-negative and emit that as the root bit.
module sqrt_step #(
    parameter int REM_W  = 58,
    parameter int ROOT_W = 54
) (
    input  logic [REM_W-3:0]  rem_in,
    input  logic [1:0]        pair,
    input  logic [ROOT_W-1:0] root_in,
    output logic [REM_W-1:0]  rem_out,
    output logic              root_bit
);

    logic [REM_W-1:0] rem_shift;
    logic [REM_W-1:0] trial;

    assign rem_shift = {rem_in, pair};
    assign trial     = {{(REM_W-ROOT_W-2){1'b0}}, root_in, 2'b01};
    assign root_bit  = (rem_shift >= trial);
    assign rem_out   = root_bit ? (rem_shift - trial) : rem_shift;

endmodule

// File: rtl/fp_sqrt_controller.sv
// Multi-cycle FP square-root sequencer: special-operand bypass, one root bit per
// cycle through sqrt_step, then round-to-nearest-even into the IEEE result.
module fp_sqrt_controller
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic     clk,
    input  logic     rst_n,
    fp_sqrt_if.slave bus
);

    localparam int ROOT_W = FRAC_W + 2;
    localparam int REM_W  = FRAC_W + 6;
    localparam int RAD_W  = 2 * (FRAC_W + 3);
    localparam int CNT_W  = $clog2(FRAC_W + 3);

    state_t             state_reg;
    logic               type_reg;
    logic [63:0]        operand_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [RAD_W-1:0]   rad_reg;
    logic [REM_W-1:0]   rem_reg;
    logic [ROOT_W-1:0]  root_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               invalid_reg;
    logic [63:0]        result_reg;

    // Radicand taken straight from the bus at acceptance. A single fraction is
    // left-aligned, so both precisions share one bit alignment and the single
    // root is simply the first 26 bits of the same recurrence.
    logic               acc_odd;
    logic [FRAC_W-1:0]  acc_frac;
    logic [RAD_W-1:0]   rad_init;

    assign acc_odd  = bus.op_type ? bus.operand[FRAC_W] : bus.operand[23];
    assign acc_frac = bus.op_type ? bus.operand[FRAC_W-1:0]
                                  : {bus.operand[22:0], {(FRAC_W-23){1'b0}}};
    assign rad_init = acc_odd ? {2'b01, acc_frac, {(RAD_W-FRAC_W-2){1'b0}}}
                              : {1'b1,  acc_frac, {(RAD_W-FRAC_W-1){1'b0}}};

    logic [EXP_W-1:0]   lat_exp;
    logic [EXP_W-1:0]   out_exp;

    assign lat_exp = type_reg ? operand_reg[FRAC_W +: EXP_W]
                              : {{(EXP_W-8){1'b0}}, operand_reg[30:23]};

    exponent_handler #(.EXP_W(EXP_W)) u_exp (
        .in_exp  (lat_exp),
        .dp      (type_reg),
        .out_exp (out_exp)
    );

    logic [REM_W-1:0]   step_rem;
    logic               step_bit;

    sqrt_step #(.REM_W(REM_W), .ROOT_W(ROOT_W)) u_step (
        .rem_in   (rem_reg[REM_W-3:0]),
        .pair     (rad_reg[RAD_W-1 -: 2]),
        .root_in  (root_reg),
        .rem_out  (step_rem),
        .root_bit (step_bit)
    );

    // The hidden bit shifts out of root_reg on the last double step; it is
    // implied by the result exponent. A mantissa carry ripples into the
    // exponent field and leaves the fraction zero.
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [EXP_W+FRAC_W-1:0] word_dp;
    logic [30:0]             word_sp;
    logic [63:0]             norm_result;

    assign guard       = root_reg[1];
    assign sticky      = root_reg[0] | (|rem_reg);
    assign round_up    = guard & (sticky | root_reg[2]);
    assign word_dp     = {out_exp, root_reg[FRAC_W+1:2]}
                       + {{(EXP_W+FRAC_W-1){1'b0}}, round_up};
    assign word_sp     = {out_exp[7:0], root_reg[24:2]} + {30'd0, round_up};
    assign norm_result = type_reg ? {1'b0, word_dp} : {32'd0, 1'b0, word_sp};

    logic [64:0]        spec_word;
    logic [CNT_W-1:0]   last_iter;

    assign spec_word = special_result(type_reg, operand_reg);
    assign last_iter = type_reg ? CNT_W'(ITERS_DP - 1) : CNT_W'(ITERS_SP - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            type_reg    <= 1'b0;
            operand_reg <= '0;
            cnt_reg     <= '0;
            rad_reg     <= '0;
            rem_reg     <= '0;
            root_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            invalid_reg <= 1'b0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        type_reg    <= bus.op_type;
                        operand_reg <= bus.operand;
                        cnt_reg     <= '0;
                        rad_reg     <= rad_init;
                        rem_reg     <= '0;
                        root_reg    <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= is_special(bus.op_type, bus.operand) ? SPECIAL : ITER;
                    end
                end
                SPECIAL: begin
                    invalid_reg <= spec_word[64];
                    result_reg  <= spec_word[63:0];
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b1;
                    state_reg   <= DONE;
                end
                ITER: begin
                    rad_reg  <= {rad_reg[RAD_W-3:0], 2'b00};
                    rem_reg  <= step_rem;
                    root_reg <= {root_reg[ROOT_W-2:0], step_bit};
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == last_iter) begin
                        state_reg <= ROUND;
                    end
                end
                ROUND: begin
                    invalid_reg <= 1'b0;
                    result_reg  <= norm_result;
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b1;
                    state_reg   <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.result  = result_reg;
    assign bus.invalid = invalid_reg;

endmodule

// File: tb/tb_fp_sqrt_controller.sv
// Directed bench for fp_sqrt_controller: a real-arithmetic reference model feeds a
// scoreboard that one monitor checks against the handshake outputs every cycle.
module tb_fp_sqrt_controller;

    logic clk;
    logic rst_n;

    fp_sqrt_if bus ();

    fp_sqrt_controller #(.EXP_W(11), .FRAC_W(52)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        inv;
        int          lat;
    } mres_t;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          vecs = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [63:0] last_res = 64'd0;
    logic        last_inv = 1'b0;

    // Reference: IEEE rules for special operands, host sqrt for the rest.
    // Single precision goes through an exact widening to double, then RNE back.
    function automatic mres_t model(input logic dp, input logic [63:0] op);
        mres_t       m;
        logic [63:0] d;
        logic [63:0] rb;
        logic [10:0] de;
        logic [30:0] w;
        m.inv = 1'b0;
        m.lat = 2;
        m.res = 64'd0;
        if (dp) begin
            if (op[62:52] == 11'h7FF && op[51:0] != 52'd0) m.res = op | 64'h0008_0000_0000_0000;
            else if (op[62:52] == 11'd0) m.res = {op[63], 63'd0};
            else if (op[63]) begin m.res = 64'h7FF8_0000_0000_0000; m.inv = 1'b1; end
            else if (op[62:52] == 11'h7FF) m.res = op;
            else begin
                m.res = $realtobits($sqrt($bitstoreal(op)));
                m.lat = 57;
            end
        end else begin
            if (op[30:23] == 8'hFF && op[22:0] != 23'd0) m.res = {32'd0, op[31:0] | 32'h0040_0000};
            else if (op[30:23] == 8'd0) m.res = {32'd0, op[31], 31'd0};
            else if (op[31]) begin m.res = 64'h0000_0000_7FC0_0000; m.inv = 1'b1; end
            else if (op[30:23] == 8'hFF) m.res = {32'd0, op[31:0]};
            else begin
                d  = {1'b0, {3'd0, op[30:23]} + 11'd896, op[22:0], 29'd0};
                rb = $realtobits($sqrt($bitstoreal(d)));
                de = rb[62:52] - 11'd896;
                w  = {de[7:0], rb[51:29]} + {30'd0, rb[28] & ((|rb[27:0]) | rb[29])};
                m.res = {32'd0, 1'b0, w};
                m.lat = 28;
            end
        end
        return m;
    endfunction

    // Monitor: one check per cycle, 1 time unit after the rising edge.
    initial begin
        exp_t e;
        int   lat;
        logic busy_exp;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            vecs++;
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_done: got done=1 result=%h, want done=0 (nothing in flight)", bus.result);
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.acc + 1;
                    if (bus.result !== e.res || bus.invalid !== e.inv || lat != e.lat || bus.busy !== 1'b0) begin
                        fails++;
                        $display("FAIL %s: got result=%h invalid=%b latency=%0d busy=%b, want result=%h invalid=%b latency=%0d busy=0",
                                 e.name, bus.result, bus.invalid, lat, bus.busy, e.res, e.inv, e.lat);
                    end else begin
                        $display("ok   %s: result=%h invalid=%b latency=%0d", e.name, bus.result, bus.invalid, lat);
                    end
                    last_res = e.res;
                    last_inv = e.inv;
                end
            end else begin
                busy_exp = (exp_q.size() != 0) && (cyc >= exp_q[0].acc);
                if (bus.result !== last_res || bus.invalid !== last_inv || bus.busy !== busy_exp || bus.done !== 1'b0) begin
                    fails++;
                    $display("FAIL hold@%0d: got result=%h invalid=%b busy=%b done=%b, want result=%h invalid=%b busy=%b done=0",
                             cyc, bus.result, bus.invalid, bus.busy, bus.done, last_res, last_inv, busy_exp);
                end
                if (exp_q.size() != 0 && cyc - exp_q[0].acc > 100) begin
                    vecs++;
                    fails++;
                    $display("FAIL timeout_%s: got no done after %0d edges, want done at %0d",
                             exp_q[0].name, cyc - exp_q[0].acc + 1, exp_q[0].lat);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic dp, input logic [63:0] op,
                          input bit has_lit, input logic [63:0] lit_res, input logic lit_inv,
                          input int lit_lat, input bit poke);
        mres_t m;
        exp_t  e;
        m = model(dp, op);
        if (has_lit) begin
            vecs++;
            if (m.res !== lit_res || m.inv !== lit_inv || m.lat != lit_lat) begin
                fails++;
                $display("FAIL model_%s: model gives result=%h invalid=%b latency=%0d, want result=%h invalid=%b latency=%0d",
                         name, m.res, m.inv, m.lat, lit_res, lit_inv, lit_lat);
            end
        end
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op_type = dp;
        bus.operand = op;
        e.name = name;
        e.res  = m.res;
        e.inv  = m.inv;
        e.lat  = m.lat;
        e.acc  = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.operand = {$urandom, $urandom};
        bus.op_type = 1'($urandom);
        if (poke) begin
            repeat (4) @(negedge clk);
            bus.start   = 1'b1;
            bus.op_type = ~dp;
            bus.operand = 64'h4022_0000_4110_0000;
            @(negedge clk);
            bus.start   = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.op_type = 1'b0;
        bus.operand = 64'd0;
        rst_n       = 1'b1;
        #2 rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0 || bus.invalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h invalid=%b, want all zero",
                     bus.busy, bus.done, bus.result, bus.invalid);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sp_4.0",      1'b0, 64'hDEAD_BEEF_4080_0000, 1, 64'h0000_0000_4000_0000, 1'b0, 28, 0);
        run_op("sp_2.0",      1'b0, 64'h0000_0000_4000_0000, 1, 64'h0000_0000_3FB5_04F3, 1'b0, 28, 0);
        run_op("dp_2.0",      1'b1, 64'h4000_0000_0000_0000, 1, 64'h3FF6_A09E_667F_3BCD, 1'b0, 57, 0);
        run_op("sp_-1.0",     1'b0, 64'h0000_0000_BF80_0000, 1, 64'h0000_0000_7FC0_0000, 1'b1, 2, 0);
        run_op("sp_-0",       1'b0, 64'h1234_5678_8000_0000, 1, 64'h0000_0000_8000_0000, 1'b0, 2, 0);
        run_op("dp_+inf",     1'b1, 64'h7FF0_0000_0000_0000, 1, 64'h7FF0_0000_0000_0000, 1'b0, 2, 0);
        run_op("sp_snan",     1'b0, 64'h0000_0000_7F80_0001, 1, 64'h0000_0000_7FC0_0001, 1'b0, 2, 0);
        run_op("sp_1.0",      1'b0, 64'h0000_0000_3F80_0000, 1, 64'h0000_0000_3F80_0000, 1'b0, 28, 0);
        run_op("sp_9.0",      1'b0, 64'h0000_0000_4110_0000, 1, 64'h0000_0000_4040_0000, 1'b0, 28, 0);
        run_op("dp_4.0",      1'b1, 64'h4010_0000_0000_0000, 1, 64'h4000_0000_0000_0000, 1'b0, 57, 0);
        run_op("dp_-inf",     1'b1, 64'hFFF0_0000_0000_0000, 1, 64'h7FF8_0000_0000_0000, 1'b1, 2, 0);
        run_op("dp_neg_snan", 1'b1, 64'hFFF0_0000_0000_0001, 1, 64'hFFF8_0000_0000_0001, 1'b0, 2, 0);
        run_op("sp_subnorm",  1'b0, 64'h0000_0000_0000_0001, 1, 64'h0000_0000_0000_0000, 1'b0, 2, 0);
        run_op("sp_+inf",     1'b0, 64'h0000_0000_7F80_0000, 1, 64'h0000_0000_7F80_0000, 1'b0, 2, 0);
        run_op("sp_max",      1'b0, 64'h0000_0000_7F7F_FFFF, 1, 64'h0000_0000_5F7F_FFFF, 1'b0, 28, 0);

        run_op("dp_1.5",      1'b1, 64'h3FF8_0000_0000_0000, 0, 64'd0, 1'b0, 0, 0);
        run_op("dp_pi",       1'b1, 64'h4009_21FB_5444_2D18, 0, 64'd0, 1'b0, 0, 0);
        run_op("dp_tiny",     1'b1, 64'h0010_0000_0000_0001, 0, 64'd0, 1'b0, 0, 0);
        run_op("sp_3.0",      1'b0, 64'h0000_0000_4040_0000, 0, 64'd0, 1'b0, 0, 0);
        run_op("sp_0.1",      1'b0, 64'h0000_0000_3DCC_CCCD, 0, 64'd0, 1'b0, 0, 0);

        // start while busy with another operand must be ignored
        run_op("sp_4.0_poke", 1'b0, 64'h0000_0000_4080_0000, 1, 64'h0000_0000_4000_0000, 1'b0, 28, 1);
        run_op("dp_2.0_poke", 1'b1, 64'h4000_0000_0000_0000, 1, 64'h3FF6_A09E_667F_3BCD, 1'b0, 57, 1);

        // reset in the middle of the iteration aborts the operation
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op_type = 1'b0;
        bus.operand = 64'h0000_0000_4110_0000;
        begin
            exp_t e;
            e.name = "aborted";
            e.res  = 64'h0000_0000_4040_0000;
            e.inv  = 1'b0;
            e.lat  = 28;
            e.acc  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        last_res = 64'd0;
        last_inv = 1'b0;
        #1;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0 || bus.invalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got busy=%b done=%b result=%h invalid=%b, want all zero",
                     bus.busy, bus.done, bus.result, bus.invalid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run_op("after_reset", 1'b0, 64'h0000_0000_4080_0000, 1, 64'h0000_0000_4000_0000, 1'b0, 28, 0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
